// File: rtl/udp_echo_responder.sv
// Store-and-forward UDP echo: one datagram buffered, then replayed to the sender with its measured byte count.
// Latency: RX last -> TX meta valid 1 cycle; RX is stalled (ready=0) while the stored datagram is echoed.
module udp_echo_responder #(
  parameter int WIDTH      = 64,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                 net_clk,
  input  logic                 net_aresetn,
  input  logic                 s_axis_udp_rx_metadata_vld,
  output logic                 s_axis_udp_rx_metadata_rdy,
  input  logic [175:0]         s_axis_udp_rx_metadata_dat,
  input  logic                 s_axis_udp_rx_data_vld,
  output logic                 s_axis_udp_rx_data_rdy,
  input  logic [WIDTH-1:0]     s_axis_udp_rx_data_dat,
  input  logic [WIDTH/8-1:0]   s_axis_udp_rx_data_keep,
  input  logic                 s_axis_udp_rx_data_last,
  output logic                 m_axis_udp_tx_metadata_vld,
  input  logic                 m_axis_udp_tx_metadata_rdy,
  output logic [175:0]         m_axis_udp_tx_metadata_dat,
  output logic                 m_axis_udp_tx_data_vld,
  input  logic                 m_axis_udp_tx_data_rdy,
  output logic [WIDTH-1:0]     m_axis_udp_tx_data_dat,
  output logic [WIDTH/8-1:0]   m_axis_udp_tx_data_keep,
  output logic                 m_axis_udp_tx_data_last,
  output logic [31:0]          echo_cnt,
  output logic [31:0]          drop_cnt
);

  localparam int KW  = WIDTH / 8;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;
  localparam int BSH = $clog2(KW);
  localparam logic [AW:0] FULL    = AW1'(FIFO_DEPTH);
  localparam logic [16:0] DEPTH_W = 17'(FIFO_DEPTH);
  localparam logic [16:0] ROUND   = 17'(KW - 1);

  typedef struct packed {
    logic [15:0]  len;
    logic [15:0]  lport;
    logic [15:0]  rport;
    logic [127:0] ip;
  } meta_t;

  typedef enum logic [2:0] {IDLE, STORE, DROP, META, DATA} state_t;

  state_t          state, state_nxt;
  logic            live;
  meta_t           rx_meta;
  meta_t           tx_meta;
  logic [127:0]    ip_q;
  logic [15:0]     rport_q, lport_q;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [15:0]     byte_cnt, bytes_nxt;
  logic [16:0]     byte_sum, need;
  logic            full, store_wr, tx_data_hs, echo_inc, drop_inc;

  logic [WIDTH-1:0] dat_mem  [FIFO_DEPTH];
  logic [KW-1:0]    keep_mem [FIFO_DEPTH];

  function automatic logic [15:0] popcnt(input logic [KW-1:0] k);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < KW; i++) n = n + 16'(k[i]);
    return n;
  endfunction

  assign rx_meta   = s_axis_udp_rx_metadata_dat;
  assign need      = ({1'b0, rx_meta.len} + ROUND) >> BSH;
  assign full      = (wr_ptr == FULL);
  // Byte total saturates rather than wrapping so a huge datagram never reads as empty.
  assign byte_sum  = {1'b0, byte_cnt} + {1'b0, popcnt(s_axis_udp_rx_data_keep)};
  assign bytes_nxt = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
  assign store_wr  = (state == STORE) && s_axis_udp_rx_data_vld && !full;
  assign tx_data_hs = m_axis_udp_tx_data_vld && m_axis_udp_tx_data_rdy;

  always_comb begin
    tx_meta       = '0;
    tx_meta.ip    = ip_q;
    tx_meta.rport = rport_q;
    tx_meta.lport = lport_q;
    tx_meta.len   = byte_cnt;
  end

  assign m_axis_udp_tx_metadata_dat = tx_meta;
  assign m_axis_udp_tx_data_dat     = dat_mem[rd_ptr[AW-1:0]];
  assign m_axis_udp_tx_data_keep    = keep_mem[rd_ptr[AW-1:0]];
  assign m_axis_udp_tx_data_last    = (state == DATA) && (rd_ptr == wr_ptr - AW1'(1));

  always_ff @(posedge net_clk or negedge net_aresetn) begin
    if (!net_aresetn) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt                  = state;
    s_axis_udp_rx_metadata_rdy = 1'b0;
    s_axis_udp_rx_data_rdy     = 1'b0;
    m_axis_udp_tx_metadata_vld = 1'b0;
    m_axis_udp_tx_data_vld     = 1'b0;
    echo_inc                   = 1'b0;
    drop_inc                   = 1'b0;
    unique case (state)
      IDLE: begin
        s_axis_udp_rx_metadata_rdy = live;
        if (live && s_axis_udp_rx_metadata_vld)
          state_nxt = (need > DEPTH_W) ? DROP : STORE;
      end
      STORE: begin
        s_axis_udp_rx_data_rdy = 1'b1;
        if (s_axis_udp_rx_data_vld) begin
          // A beat arriving with the buffer already full cannot be kept.
          if (full) begin
            if (s_axis_udp_rx_data_last) begin
              drop_inc  = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = DROP;
            end
          end else if (s_axis_udp_rx_data_last) begin
            if (bytes_nxt == 16'd0) begin
              drop_inc  = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = META;
            end
          end
        end
      end
      DROP: begin
        s_axis_udp_rx_data_rdy = 1'b1;
        if (s_axis_udp_rx_data_vld && s_axis_udp_rx_data_last) begin
          drop_inc  = 1'b1;
          state_nxt = IDLE;
        end
      end
      META: begin
        m_axis_udp_tx_metadata_vld = 1'b1;
        if (m_axis_udp_tx_metadata_rdy) state_nxt = DATA;
      end
      DATA: begin
        m_axis_udp_tx_data_vld = 1'b1;
        if (m_axis_udp_tx_data_rdy && m_axis_udp_tx_data_last) begin
          echo_inc  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge net_clk or negedge net_aresetn) begin
    if (!net_aresetn) begin
      live     <= 1'b0;
      ip_q     <= '0;
      rport_q  <= '0;
      lport_q  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      byte_cnt <= '0;
      echo_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      live <= 1'b1;
      if (state == IDLE && live && s_axis_udp_rx_metadata_vld) begin
        ip_q     <= rx_meta.ip;
        rport_q  <= rx_meta.rport;
        lport_q  <= rx_meta.lport;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        byte_cnt <= '0;
      end
      if (store_wr) begin
        wr_ptr   <= wr_ptr + AW1'(1);
        byte_cnt <= bytes_nxt;
      end
      if (tx_data_hs) begin
        if (m_axis_udp_tx_data_last) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end else begin
          rd_ptr <= rd_ptr + AW1'(1);
        end
      end
      if (echo_inc) echo_cnt <= echo_cnt + 32'd1;
      if (drop_inc) drop_cnt <= drop_cnt + 32'd1;
    end
  end

  // Payload storage carries no reset; only entries below wr_ptr are ever replayed.
  always_ff @(posedge net_clk) begin
    if (store_wr) begin
      dat_mem[wr_ptr[AW-1:0]]  <= s_axis_udp_rx_data_dat;
      keep_mem[wr_ptr[AW-1:0]] <= s_axis_udp_rx_data_keep;
    end
  end

endmodule
